// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output never glitches out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop.
// Good words are delivered with a one-cycle valid strobe; bad stop bits with frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS) + 1;

  logic                 rx_s;
  uart_state_e          state;
  logic [3:0]           sub;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sub       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          sub  <= '0;
          busy <= 1'b0;
          if (rx_s) armed <= 1'b1;
          // Only a high-to-low transition starts a frame; a line held low
          // after a framing error must first return high to re-arm.
          if (armed && !rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
            armed <= 1'b0;
          end
        end
        S_START: begin
          if (tick16) begin
            if (sub == MID_SAMPLE) begin
              sub <= '0;
              if (!rx_s) begin
                state  <= S_DATA;
                bitcnt <= '0;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick16) begin
            sub <= sub + 4'd1;
            if (sub == LAST_SAMPLE) begin
              shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BW'(DATA_BITS - 1)) state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick16) begin
            sub <= sub + 4'd1;
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            if (sub == LAST_SAMPLE) begin
              if (rx_s) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: an 8-bit and a 7-bit receiver,
// each fed by a behavioural line driver that queues the expected strobes.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  typedef struct {
    bit         err;
    logic [8:0] data;
  } exp_t;

  logic       clk, rst, tick16, rx8, rx7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, frame_err8, busy8;
  logic       valid7, frame_err7, busy7;

  exp_t       q8[$];
  exp_t       q7[$];
  logic [8:0] last_good8, last_good7;
  int         checks, failures;

  uart_rx #(.DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .tick16(tick16), .rx(rx8),
    .data(data8), .valid(valid8), .frame_err(frame_err8), .busy(busy8)
  );

  uart_rx #(.DATA_BITS(7)) dut7 (
    .clk(clk), .rst(rst), .tick16(tick16), .rx(rx7),
    .data(data7), .valid(valid7), .frame_err(frame_err7), .busy(busy7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick16 every 4 clk: one bit = 64 clk
  initial begin
    tick16 = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick16 = 1'b1;
      @(posedge clk);
      #1 tick16 = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever either receiver strobes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid8 && frame_err8) check("both_strobes8", 1, 0);
      if (valid7 && frame_err7) check("both_strobes7", 1, 0);
      if (valid8 || frame_err8) begin
        if (q8.size() == 0) check("unexpected_strobe8", {valid8, frame_err8}, 0);
        else begin
          e = q8.pop_front();
          check("kind8", {valid8, frame_err8}, e.err ? 2'b01 : 2'b10);
          check("data8", data8, e.data[7:0]);
        end
      end
      if (valid7 || frame_err7) begin
        if (q7.size() == 0) check("unexpected_strobe7", {valid7, frame_err7}, 0);
        else begin
          e = q7.pop_front();
          check("kind7", {valid7, frame_err7}, e.err ? 2'b01 : 2'b10);
          check("data7", data7, e.data[6:0]);
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input int clks);
    if (sel) rx7 = v; else rx8 = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // Model: a frame yields either its data (good stop) or a framing error with
  // the previously delivered word still on the output.
  task automatic send(input bit sel, input int nb, input logic [8:0] d, input logic stop);
    exp_t       e;
    logic [8:0] m;
    m = d & ((9'd1 << nb) - 9'd1);
    e.err = !stop;
    if (sel) begin
      if (stop) last_good7 = m;
      e.data = last_good7;
      q7.push_back(e);
    end else begin
      if (stop) last_good8 = m;
      e.data = last_good8;
      q8.push_back(e);
    end
    drive(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < nb; i++) drive(sel, m[i], BIT_CLKS);
    drive(sel, stop, BIT_CLKS);
    if (sel) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  initial begin
    logic [8:0] bits;
    checks = 0; failures = 0;
    last_good8 = '0; last_good7 = '0;
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data8", data8, 0);
    check("rst_outs8", {valid8, frame_err8, busy8}, 0);
    check("rst_data7", data7, 0);
    check("rst_outs7", {valid7, frame_err7, busy7}, 0);
    drive(0, 1'b1, 2 * BIT_CLKS);

    // good frames with idle gap
    send(0, 8, 9'hA5, 1'b1);
    drive(0, 1'b1, BIT_CLKS);
    check("busy_idle", busy8, 0);
    send(0, 8, 9'h3C, 1'b1);
    drive(0, 1'b1, BIT_CLKS);
    check("data_hold", data8, 8'h3C);

    // glitch: 4 tick16 low
    send(0, 8, 9'hA5, 1'b1);
    drive(0, 1'b1, BIT_CLKS);
    drive(0, 1'b0, 10);
    check("glitch_busy_hi", busy8, 1);
    drive(0, 1'b0, 6);
    drive(0, 1'b1, BIT_CLKS);
    check("glitch_busy_lo", busy8, 0);

    // framing error, line held low two more bit times
    send(0, 8, 9'h3C, 1'b0);
    drive(0, 1'b0, 2 * BIT_CLKS - 8);
    check("break_no_start", busy8, 0);
    drive(0, 1'b0, 8);
    check("fe_data_kept", data8, 8'hA5);
    drive(0, 1'b1, BIT_CLKS);
    send(0, 8, 9'h55, 1'b1);

    // back-to-back frames
    drive(0, 1'b1, BIT_CLKS);
    send(0, 8, 9'h00, 1'b1);
    send(0, 8, 9'hFF, 1'b1);
    send(0, 8, 9'h81, 1'b1);
    drive(0, 1'b1, BIT_CLKS);

    // reset during data bit 4 of 0xC3
    bits = 9'h0C3;
    drive(0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(0, bits[i], BIT_CLKS);
    drive(0, bits[4], 32);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx8 = 1'b1;
    check("midrst_data8", data8, 0);
    check("midrst_outs8", {valid8, frame_err8, busy8}, 0);
    rst = 1'b0;
    last_good8 = '0; last_good7 = '0;
    drive(0, 1'b1, 2 * BIT_CLKS);
    check("postrst_idle", {valid8, frame_err8, busy8, data8}, 0);
    send(0, 8, 9'h5A, 1'b1);
    drive(0, 1'b1, BIT_CLKS);

    // 7-bit variant
    send(1, 7, 9'h02B, 1'b1);
    drive(1, 1'b1, BIT_CLKS);
    check("var7_data", data7, 7'h2B);

    // randomized traffic on both widths
    for (int n = 0; n < 30; n++) begin
      bit         sel;
      logic       stop;
      int         gap;
      sel  = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? 16 * $urandom_range(0, 3) : BIT_CLKS + $urandom_range(0, 64);
      send(sel, sel ? 7 : 8, 9'($urandom_range(0, 511)), stop);
      if (gap > 0) drive(sel, 1'b1, gap);
    end

    drive(0, 1'b1, 3 * BIT_CLKS);
    check("q8_drained", q8.size(), 0);
    check("q7_drained", q7.size(), 0);
    check("final_idle", {busy8, busy7}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: 16x oversampled, LSB first, 1 start, DATA_BITS data, 1 stop, no parity. It pairs with the existing UART transmitter and shares its 16x `tick16` baud generator. It sits between the asynchronous `rx` pin and the parallel consumer (loopback/echo logic, command decoder). It delivers each good byte as a one-cycle strobe and flags framing errors separately.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `clk`  in  1: single system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tick16`  in  1: one-`clk` strobe at 16x baud from the baud generator.
- `rx`  in  1: asynchronous serial line; idles high.
- `data`  out  DATA_BITS: last correctly framed word; holds until the next good frame.
- `valid`  out  1: one-`clk` strobe; `data` is new this cycle.
- `frame_err`  out  1: one-`clk` strobe; stop bit was sampled low.
- `busy`  out  1: high from start-bit detection until return to IDLE.

## Operation
- **Input synchronizer:** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counters:**
  - `sub` (4 bits) counts `tick16` within a bit.
  - `bitcnt` (width $clog2(DATA_BITS)+1) counts data bits.
- **States:** S_IDLE, S_START, S_DATA, S_STOP.
- **S_IDLE:**
  - Holds `sub` = 0 and `busy` = 0.
  - Register `armed` sets whenever `rx_s` = 1.
  - If `armed` and `rx_s` = 0: go to S_START, set `busy` = 1, clear `armed`.
  - `armed` prevents a stuck-low or break line from retriggering after a framing error.
- **S_START:**
  - On the `tick16` where `sub` == 7 (mid start bit): if `rx_s` = 0, go to S_DATA with `sub` = 0 and `bitcnt` = 0.
  - Otherwise it is a glitch: go to S_IDLE with no strobe.
- **S_DATA:**
  - On the `tick16` where `sub` == 15 (mid data bit), shift right: `shreg` <= {`rx_s`, `shreg`[DATA_BITS-1:1]}. This places the first bit received at bit 0.
  - Increment `bitcnt`. After the DATA_BITS-th sample, go to S_STOP.
- **S_STOP:**
  - On the `tick16` where `sub` == 15 (mid stop bit):
    - If `rx_s` = 1: `data` <= `shreg` and `valid` = 1.
    - Else: `frame_err` = 1 and `data` is unchanged.
  - In both cases go to S_IDLE.
  - The block returns to IDLE half a bit early, so back-to-back frames are accepted.
- **Counter stepping:** `sub` increments only on `tick16` and wraps 15 to 0. Elsewhere `sub` and `shreg` hold.
- **Reset:**
  - Outputs: `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - Internal: state = S_IDLE, `sub` = 0, `bitcnt` = 0, `shreg` = 0, sync flops = 1, `armed` = 0.
  - Reset mid-frame abandons the frame silently; there is no strobe.
- `valid` and `frame_err` are never high in the same cycle.
- There is no overrun detection. The consumer must take `data` before the next `valid`.

## Timing
- **Sync delay:** 2 `clk` from an `rx` edge to `rx_s`.
- **Start validation:** 8 `tick16` after detection.
- **Bit sampling:** each data bit and the stop bit is sampled 16 `tick16` after the previous sample, at bit centre.
- **Output latency:** `valid`/`frame_err` are registered. They assert in the `clk` cycle after the stop-sample `tick16` and deassert one cycle later.
- **`busy` timing:**
  - Rises the cycle after start detection.
  - Falls together with the `valid`/`frame_err` strobe on a complete frame.
  - Falls the cycle after the failing `tick16` on a rejected start.
- **Frame length:** a full frame occupies about (DATA_BITS+1.5)×16 `tick16` from the start-edge detection to the strobe.
- **Tolerance:** transmitter/receiver baud mismatch up to ±3 % is tolerated by centre sampling.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding (S_IDLE..S_STOP, 2 bits), used by both TX and RX.
  - OVERSAMPLE = 16, MID_SAMPLE = 7, LAST_SAMPLE = 15.
- **Sub-module `sync2`:** generic 2-flop synchronizer with a parameterised reset value (1 here). It is reusable for other asynchronous inputs.
- **Remainder:** one FSM always-block plus the output registers.

## Test plan
Bench setup: `tick16` every 4 `clk` (1 bit = 64 `clk`); `rx` driven by a bench model or by the existing transmitter in loopback.
- **Good frame:** send 0xA5, then 0x3C. Expect `data` = 0xA5, then 0x3C, each with exactly one `valid` pulse and `frame_err` = 0. `busy` is low between frames.
- **Glitch rejection:** drive `rx` low for 4 `tick16`, then high. Expect no `valid`, no `frame_err`, and `busy` back to 0 after the `sub` == 7 tick.
- **Framing error:** send 0x3C with the stop bit forced low, then hold the line low for 2 bit times. Expect one `frame_err` pulse and `data` still 0xA5. No new start is accepted until `rx` returns high; then 0x55 is received correctly.
- **Back-to-back frames:** send 0x00, 0xFF, 0x81 with a single stop bit and no idle gap. Expect three `valid` pulses with the correct values, and the transmitter loopback matching byte for byte.
- **Reset mid-frame:** pulse `rst` during data bit 4 of 0xC3. Expect all outputs at their reset values and no strobe. Then send 0x5A: expect `data` = 0x5A with `valid`.
- **Parameter variant:** with DATA_BITS = 7, send 0x2B. Expect `data` = 7'h2B with `valid`; a stop bit sampled at the 8th bit slot passes.
